nv_nvdla_cdma_wt_param_fifo: RTL and testbench
==============================================

// Module: nv_nvdla_cdma_wt_param_fifo
// PURPOSE
//  Parametrised synchronous valid/ready FIFO for the CDMA weight path; next generation of the fixed 32x32 weight-group FIFO.
//  Adds configurable width and depth, a runtime write limit, synchronous flush, and occupancy and almost-full status.
//  Sits between the weight-group request generator (write side) and the weight fetch sequencer (read side).
//  Read output is registered; rd_data is stable while rd_req=1 and rd_ready=0.
// PARAMETERS
//  WIDTH    32  data width in bits, >=1
//  DEPTH    32  storage entries, power of 2, >=2
//  AFULL_TH 28  afull asserts when occupancy >= AFULL_TH; 1..DEPTH
//  CW       $clog2(DEPTH+1)  occupancy width (derived; do not override)
// PORTS
//  clk            in   1      core clock; single clock domain
//  reset          in   1      synchronous, active-high reset
//  wr_req         in   1      write valid
//  wr_ready       out  1      write ready (registered)
//  wr_data        in   WIDTH  write data
//  rd_req         out  1      read valid (registered)
//  rd_ready       in   1      read ready
//  rd_data        out  WIDTH  read data (registered)
//  flush          in   1      synchronous drop of all contents
//  wr_limit       in   CW     runtime capacity cap; 0 or >DEPTH means DEPTH
//  count          out  CW     occupancy: array entries plus output register
//  afull          out  1      count >= AFULL_TH (registered)
// BEHAVIOUR
//  Reset:
//   - Reset is synchronous, active-high, sampled on the clk rising edge.
//   - Reset state: wr_ready=1, rd_req=0, count=0, afull=0, rd_data=0; pointers=0.
//  Handshakes:
//   - push = wr_req & wr_ready; pop = rd_req & rd_ready.
//   - wr_data is ignored when push=0.
//   - rd_req/rd_data hold while rd_req=1 & !rd_ready.
//  Latency:
//   - Push into an empty FIFO (count=0 or count=1 with a pop in the same cycle) gives rd_req=1 on the next cycle.
//   - Otherwise the output register reloads from the array head on the cycle after a pop, with no bubble.
//   - Back-to-back pops sustain 1 word/cycle.
//  Occupancy:
//   - count_nxt = count + push - pop. Push and pop in the same cycle leave count unchanged.
//   - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH with no special case.
//  Capacity:
//   - eff_lim = (wr_limit==0 || wr_limit>DEPTH) ? DEPTH : wr_limit.
//   - wr_ready <= (count_nxt < eff_lim), registered from next state, so overflow can never occur.
//  Full:
//   - At count=eff_lim, wr_ready=0.
//   - A pop at full raises wr_ready on the following cycle, not the same cycle.
//  Empty: rd_req=0 and rd_data keeps its last value.
//  wr_limit changes:
//   - A new wr_limit is sampled every cycle and affects wr_ready from the next cycle.
//   - If the new limit is below count, wr_ready stays 0 until count drains below it. No data is dropped.
//  afull <= (count_nxt >= AFULL_TH).
//  flush:
//   - Priority order: reset > flush > push/pop.
//   - Next cycle after flush: count=0, rd_req=0, afull=0, wr_ready=1, pointers=0.
//   - A push or pop in the flush cycle is discarded.
//   - flush while already empty is a no-op.
//  Reset or flush mid-burst: in-flight data is lost and no partial word appears on rd_data.
//  Storage:
//   - Flop or RAM array with one write and one read per cycle.
//   - Write-to-read bypass is used when the array head is written in the same cycle the output register loads.
//  Assertions (sim only): count <= DEPTH, no push when !wr_ready, rd_data stable under stall.
// TESTING
//  1 Reset, then 1 push 0xA5A5_0001 -> rd_req=1 next cycle, rd_data=0xA5A5_0001, count=1; pop -> count=0, rd_req=0.
//  2 DEPTH=32, wr_limit=0, 40 continuous pushes, rd_ready=0:
//    - wr_ready drops after 32 accepts; count=32; afull=1 from count 28.
//    - Drain -> data 0..31 in order, 1/cycle.
//  3 wr_limit=8 with 6 stored -> accepts exactly 2 more, then wr_ready=0.
//    - Change wr_limit to 4 -> wr_ready stays 0 until count=3.
//  4 Simultaneous push+pop at count=5 for 100 cycles with random data:
//    - count stays 5; output order matches a scoreboard across more than 3 pointer wraps.
//  5 flush asserted with count=17 and push+pop in the same cycle:
//    - Next cycle count=0, rd_req=0, wr_ready=1.
//    - Next push 0x1234 is the first word read.
//  6 Random wr_req/rd_ready at 70%/40% for 10k cycles, reset pulsed mid-run, WIDTH=8 and DEPTH=4 builds:
//    - Scoreboard shows zero mismatches; assertions clean.

Source files
------------

// File: rtl/nv_nvdla_cdma_wt_param_fifo.sv
// ============================================================================
// Module      : nv_nvdla_cdma_wt_param_fifo
// Description : Parametrised valid/ready weight-group FIFO with registered
//               read output, runtime write limit, flush and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nv_nvdla_cdma_wt_param_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AFULL_TH = 28,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_req,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_req,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    input  logic             flush,
    input  logic [CW-1:0]    wr_limit,
    output logic [CW-1:0]    count,
    output logic             afull
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_TH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_wr_ready;
    logic             r_rd_req;
    logic             r_afull;
    logic [WIDTH-1:0] r_rd_data;

    logic             w_push;
    logic             w_pop;
    logic             w_arr_empty;
    logic             w_load;
    logic             w_bypass;
    logic             w_from_arr;
    logic             w_wr_arr;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_eff_lim;

    // The output register holds one entry whenever rd_req is high, so the
    // array holds count - rd_req entries.
    always_comb begin
        w_push      = wr_req & r_wr_ready;
        w_pop       = r_rd_req & rd_ready;
        w_arr_empty = (r_count == CW'(r_rd_req));
        w_load      = ~r_rd_req | w_pop;
        w_bypass    = w_load & w_arr_empty & w_push;
        w_from_arr  = w_load & ~w_arr_empty;
        w_wr_arr    = w_push & ~w_bypass;
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        w_eff_lim   = ((wr_limit == '0) || (wr_limit > C_DEPTH)) ? C_DEPTH : wr_limit;
    end

    always_ff @(posedge clk) begin
        if (w_wr_arr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b1;
            r_rd_req   <= 1'b0;
            r_afull    <= 1'b0;
            r_rd_data  <= '0;
        end else if (flush) begin
            // rd_data is left untouched so no partial word is ever exposed
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b1;
            r_rd_req   <= 1'b0;
            r_afull    <= 1'b0;
        end else begin
            if (w_wr_arr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_from_arr) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_load) begin
                r_rd_req <= w_bypass | w_from_arr;
                if (w_bypass) begin
                    r_rd_data <= wr_data;
                end else if (w_from_arr) begin
                    r_rd_data <= r_mem[r_rptr];
                end
            end
            r_count    <= w_count_nxt;
            r_wr_ready <= (w_count_nxt < w_eff_lim);
            r_afull    <= (w_count_nxt >= C_AFULL);
        end
    end

    assign wr_ready = r_wr_ready;
    assign rd_req   = r_rd_req;
    assign rd_data  = r_rd_data;
    assign count    = r_count;
    assign afull    = r_afull;

    a_count_max : assert property (@(posedge clk) disable iff (reset)
        r_count <= C_DEPTH);
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        w_push |-> (r_count < C_DEPTH));
    a_stall_stable : assert property (@(posedge clk) disable iff (reset)
        (r_rd_req && !rd_ready && !flush) |=> $stable(r_rd_data));

endmodule

`default_nettype wire

// File: tb/tb_nv_nvdla_cdma_wt_param_fifo.sv
// ============================================================================
// Module      : tb_nv_nvdla_cdma_wt_param_fifo
// Description : Directed and random bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nv_nvdla_cdma_wt_param_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_req;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        flush;
    logic [5:0]  wr_limit;
    logic [5:0]  count;
    logic        afull;

    int          n_chk = 0;
    int          n_err = 0;

    logic [31:0] q[$];
    bit          m_wr_ready;
    logic [31:0] m_last;

    always #5 clk = ~clk;

    nv_nvdla_cdma_wt_param_fifo #(
        .WIDTH    (32),
        .DEPTH    (32),
        .AFULL_TH (28)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .flush    (flush),
        .wr_limit (wr_limit),
        .count    (count),
        .afull    (afull)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: the model consumes the inputs seen at the edge, then the
    // DUT outputs are compared just after the edge.
    task automatic step();
        int lim;
        bit push;
        bit pop;
        @(posedge clk);
        lim = ((wr_limit == 0) || (wr_limit > 32)) ? 32 : int'(wr_limit);
        if (reset) begin
            q.delete();
            m_last     = '0;
            m_wr_ready = 1'b1;
        end else if (flush) begin
            q.delete();
            m_wr_ready = 1'b1;
        end else begin
            push = wr_req && m_wr_ready;
            pop  = (q.size() > 0) && rd_ready;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(wr_data);
            m_wr_ready = (q.size() < lim);
        end
        if (q.size() > 0) m_last = q[0];
        #1;
        chk("wr_ready", wr_ready, m_wr_ready);
        chk("rd_req",   rd_req,   q.size() > 0);
        chk("rd_data",  rd_data,  m_last);
        chk("count",    count,    q.size());
        chk("afull",    afull,    q.size() >= 28);
    endtask

    initial begin
        reset    = 1'b1;
        wr_req   = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        wr_limit = '0;
        step();
        step();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_req",   rd_req,   0);
        chk("rst_count",    count,    0);
        chk("rst_rd_data",  rd_data,  0);
        reset = 1'b0;
        step();

        // single word
        wr_req  = 1'b1;
        wr_data = 32'hA5A5_0001;
        step();
        wr_req = 1'b0;
        chk("t1_rd_req",  rd_req,  1);
        chk("t1_rd_data", rd_data, 32'hA5A5_0001);
        chk("t1_count",   count,   1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t1_pop_count",  count,  0);
        chk("t1_pop_rd_req", rd_req, 0);

        // fill to DEPTH and drain
        wr_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = i;
            step();
        end
        wr_req = 1'b0;
        chk("t2_count",    count,    32);
        chk("t2_wr_ready", wr_ready, 0);
        chk("t2_afull",    afull,    1);
        rd_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("t2_drain", rd_data, i);
            step();
        end
        rd_ready = 1'b0;
        chk("t2_empty", count, 0);

        // runtime limit
        wr_limit = 6'd8;
        wr_req   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_data = 100 + i;
            step();
        end
        wr_req = 1'b0;
        chk("t3_count",    count,    8);
        chk("t3_wr_ready", wr_ready, 0);
        wr_limit = 6'd4;
        step();
        chk("t3_lim4_wr_ready", wr_ready, 0);
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rd_ready = 1'b0;
        chk("t3_drain_count",    count,    3);
        chk("t3_drain_wr_ready", wr_ready, 1);

        // steady push+pop at count 5
        wr_limit = '0;
        wr_req   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_data = 200 + i;
            step();
        end
        chk("t4_start", count, 5);
        rd_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_data = $urandom;
            step();
            chk("t4_count", count, 5);
        end
        rd_ready = 1'b0;

        // flush with traffic in the same cycle
        for (int i = 0; i < 12; i++) begin
            wr_data = $urandom;
            step();
        end
        chk("t5_count", count, 17);
        flush    = 1'b1;
        rd_ready = 1'b1;
        step();
        flush    = 1'b0;
        wr_req   = 1'b0;
        rd_ready = 1'b0;
        chk("t5_count0",   count,    0);
        chk("t5_rd_req",   rd_req,   0);
        chk("t5_wr_ready", wr_ready, 1);
        wr_req  = 1'b1;
        wr_data = 32'h1234;
        step();
        wr_req = 1'b0;
        chk("t5_first", rd_data, 32'h1234);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();

        // random traffic with a mid-run reset
        for (int c = 0; c < 10000; c++) begin
            wr_req   = ($urandom_range(0, 99) < 70);
            rd_ready = ($urandom_range(0, 99) < 40);
            wr_data  = $urandom;
            flush    = ($urandom_range(0, 199) == 0);
            reset    = (c == 5000);
            if ((c % 500) == 0) begin
                wr_limit = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(0, 40));
            end
            step();
        end
        reset  = 1'b0;
        flush  = 1'b0;
        wr_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
